valid_delay_pipe: RTL and testbench
===================================

VALID_DELAY_PIPE -- requirements
Module: valid_delay_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width in bits.
REQ-002 The block SHALL have parameter MAX_DEPTH, default 8, number of physical stages (legal range 2..64).
REQ-003 The block SHALL have parameter DEFAULT_DEPTH, default 5, the active depth loaded at reset (legal range 1..MAX_DEPTH).
REQ-004 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1, reset; SHALL be synchronous and active-high.
REQ-006 Port in_valid, input, 1, the input word is present.
REQ-007 Port in_data, input, WIDTH, the input word.
REQ-008 Port stall, input, 1, hold every stage when high.
REQ-009 Port flush, input, 1, discard all in-flight words.
REQ-010 Port depth_load, input, 1, request to change the active depth.
REQ-011 Port depth_sel, input, DW = clog2(MAX_DEPTH+1), the requested depth.
REQ-012 Port in_ready, output, 1, equals ~stall (combinational).
REQ-013 Port out_valid, output, 1, the output word is valid.
REQ-014 Port out_data, output, WIDTH, the output word.
REQ-015 Port depth, output, DW, the active depth register (cfg_depth).
REQ-016 Port occupancy, output, DW, count of valid words within active stages 0..cfg_depth-1.
REQ-017 Port busy, output, 1, (occupancy != 0).
REQ-018 Port cfg_err, output, 1, one-cycle pulse when a depth_load is rejected.

Function
REQ-019 The block SHALL hold MAX_DEPTH stage registers, each holding a valid bit and a WIDTH data field; s[0] is the input stage.
REQ-020 When stall=0 and flush=0, the block SHALL load s[0] <= {in_valid, in_data} and s[i] <= s[i-1] for i = 1..MAX_DEPTH-1.
REQ-021 A stage valid bit with index i >= cfg_depth SHALL load 0 regardless of shift, so words never persist beyond the tap.
REQ-022 out_valid/out_data SHALL be driven directly from s[cfg_depth-1] with no added register; a word accepted at edge N SHALL appear at the output after edge N+cfg_depth-1 (latency = cfg_depth cycles, depth 1 = single register).
REQ-023 Data fields SHALL shift even when valid=0; only valid bits carry meaning.
REQ-024 When stall=1 and flush=0, every stage SHALL hold and in_valid SHALL be ignored; the output SHALL remain constant.
REQ-025 When flush=1, all valid bits SHALL clear on that edge, regardless of stall and in_valid (the input word is dropped); data fields may keep any value.
REQ-026 The effective requested depth SHALL be clamped: 0 -> 1, and values > MAX_DEPTH -> MAX_DEPTH.
REQ-027 A depth_load SHALL be accepted when busy=0 or flush=1 in the same cycle, and cfg_depth SHALL take the clamped value at that edge; a word entering s[0] on the same edge SHALL use the new depth.
REQ-028 A depth_load with busy=1 and flush=0 SHALL be ignored, and cfg_err SHALL be 1 on the following cycle only.
REQ-029 depth_load SHALL be honoured independently of stall.
REQ-030 occupancy SHALL be registered and equal the popcount of the valid bits s[0..cfg_depth-1] after each edge; the maximum value is cfg_depth.
REQ-031 Exactly one word per cycle SHALL enter and at most one SHALL exit; there SHALL be no backpressure from the output side.

Reset
REQ-032 With rst=1 at an edge, all valid bits SHALL be 0, all data fields 0, cfg_depth = DEFAULT_DEPTH, occupancy 0, and cfg_err 0.
REQ-033 rst SHALL take priority over flush, stall and depth_load; a reset mid-stream SHALL discard all words, and in_valid during reset SHALL be ignored.
REQ-034 After reset, out_valid=0, out_data=0, busy=0, depth=DEFAULT_DEPTH.

Verification
REQ-035 Latency: defaults; send 0xA5A5_0001 at edge 0 with no stall -> out_valid=1 and out_data=0xA5A5_0001 after edge 4 only; occupancy steps 1,1,1,1,1 then 0.
REQ-036 Stream plus stall: send 1..6 back-to-back at depth 5, stall for 3 cycles after the third word -> the output sequence is 1..6 with no gaps or duplicates, the output is frozen during the stall, and occupancy peaks at 5.
REQ-037 Depth change: while idle, depth_load with depth_sel=0 -> depth=1 and the next word has 1-cycle latency; depth_sel=12 (MAX_DEPTH 8) -> depth=8.
REQ-038 Rejected change: depth_load=1 with a word in flight -> depth is unchanged, cfg_err=1 for exactly one cycle, and the stream is unaffected.
REQ-039 Flush: with 4 words in flight, flush=1 together with stall=1, in_valid=1 and depth_load to 2 -> the next cycle has occupancy 0, out_valid=0 and depth=2, with no flushed word emerging later.
REQ-040 Reset mid-stream: rst=1 with 3 words in flight at depth 3 -> all outputs take their REQ-034 values and depth=5; no stale word appears afterwards.

Source files
------------

// File: rtl/valid_delay_pipe.sv
// Fixed-latency valid/data delay line with a run-time selectable tap (cfg_depth).
// Supports stall, flush, and guarded depth reconfiguration; occupancy is registered.
module valid_delay_pipe #(
  parameter int WIDTH         = 32,
  parameter int MAX_DEPTH     = 8,
  parameter int DEFAULT_DEPTH = 5,
  localparam int DW           = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  input  logic             flush,
  input  logic             depth_load,
  input  logic [DW-1:0]    depth_sel,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [DW-1:0]    depth,
  output logic [DW-1:0]    occupancy,
  output logic             busy,
  output logic             cfg_err
);

  // Handshake: a word is taken into stage 0 on every edge where in_valid=1 and
  // in_ready=1 (in_ready = ~stall); the output side has no ready and never stalls.

  logic [MAX_DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]     dat_q [MAX_DEPTH];
  logic [WIDTH-1:0]     dat_d [MAX_DEPTH];
  logic [DW-1:0]        cfg_depth_q, depth_d, sel_clamped;
  logic [DW-1:0]        occ_q, occ_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 load_ok;

  assign busy      = (occ_q != '0);
  assign in_ready  = ~stall;
  assign depth     = cfg_depth_q;
  assign occupancy = occ_q;
  assign cfg_err   = cfg_err_q;

  always_comb begin
    sel_clamped = depth_sel;
    if (depth_sel == '0)
      sel_clamped = DW'(1);
    else if (depth_sel > DW'(MAX_DEPTH))
      sel_clamped = DW'(MAX_DEPTH);

    // Reconfiguring is only safe when nothing is in flight (or everything is being dropped).
    load_ok   = depth_load && (!busy || flush);
    cfg_err_d = depth_load && busy && !flush;
    depth_d   = load_ok ? sel_clamped : cfg_depth_q;

    vld_d = vld_q;
    dat_d = dat_q;
    if (flush) begin
      vld_d = '0;
    end else if (!stall) begin
      vld_d[0] = in_valid;
      dat_d[0] = in_data;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end

    // Nothing survives past the tap, so occupancy is a plain popcount.
    occ_d = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (i >= int'(depth_d))
        vld_d[i] = 1'b0;
      occ_d = occ_d + DW'(vld_d[i]);
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (int'(cfg_depth_q) == i + 1) begin
        out_valid = vld_q[i];
        out_data  = dat_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      dat_q       <= '{default: '0};
      cfg_depth_q <= DW'(DEFAULT_DEPTH);
      occ_q       <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      dat_q       <= dat_d;
      cfg_depth_q <= depth_d;
      occ_q       <= occ_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_valid_delay_pipe.sv
// Directed and random stimulus for valid_delay_pipe, checked against a word/age
// reference model of the delay line.
module tb_valid_delay_pipe;
  localparam int WIDTH = 32;
  localparam int MAX_DEPTH = 8;
  localparam int DEFAULT_DEPTH = 5;
  localparam int DW = $clog2(MAX_DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             depth_load = 1'b0;
  logic [DW-1:0]    depth_sel = '0;
  logic             in_ready, out_valid, busy, cfg_err;
  logic [WIDTH-1:0] out_data;
  logic [DW-1:0]    depth, occupancy;

  valid_delay_pipe #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH), .DEFAULT_DEPTH(DEFAULT_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .stall(stall),
    .flush(flush), .depth_load(depth_load), .depth_sel(depth_sel), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .depth(depth), .occupancy(occupancy),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int peak_occ = 0;

  // Reference model: each in-flight word carries the number of shifts it has taken.
  typedef struct {
    logic [WIDTH-1:0] data;
    int               age;
  } word_t;
  word_t mq[$];
  int    m_depth = DEFAULT_DEPTH;
  bit    m_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_depth(input int sel);
    if (sel == 0) return 1;
    if (sel > MAX_DEPTH) return MAX_DEPTH;
    return sel;
  endfunction

  task automatic model_edge();
    word_t nq[$];
    bit was_busy;
    if (rst) begin
      mq.delete();
      m_depth = DEFAULT_DEPTH;
      m_err   = 1'b0;
      return;
    end
    was_busy = (mq.size() != 0);
    m_err = depth_load && was_busy && !flush;
    if (depth_load && (!was_busy || flush))
      m_depth = clamp_depth(int'(depth_sel));
    if (flush) begin
      mq.delete();
    end else if (!stall) begin
      foreach (mq[i]) begin
        word_t w = mq[i];
        w.age++;
        if (w.age < m_depth) nq.push_back(w);
      end
      if (in_valid) nq.push_back('{data: in_data, age: 0});
      mq = nq;
    end
  endtask

  task automatic check_outputs(input bit after_reset);
    bit               ev = 1'b0;
    logic [WIDTH-1:0] ed = '0;
    foreach (mq[i]) if (mq[i].age == m_depth - 1) begin ev = 1'b1; ed = mq[i].data; end
    chk("out_valid", 64'(out_valid), 64'(ev));
    if (ev) chk("out_data", 64'(out_data), 64'(ed));
    if (after_reset) chk("out_data_rst", 64'(out_data), 64'd0);
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("busy", 64'(busy), 64'(mq.size() != 0));
    chk("depth", 64'(depth), 64'(m_depth));
    chk("cfg_err", 64'(cfg_err), 64'(m_err));
    if (int'(occupancy) > peak_occ) peak_occ = int'(occupancy);
  endtask

  task automatic step(input bit r, input bit v, input logic [WIDTH-1:0] d, input bit st,
                      input bit fl, input bit dl, input logic [DW-1:0] sel);
    rst = r; in_valid = v; in_data = d; stall = st; flush = fl; depth_load = dl; depth_sel = sel;
    #1;
    chk("in_ready", 64'(in_ready), 64'(!st));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, $urandom, 0, 0, 0, '0);
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    step(0, 1, d, 0, 0, 0, '0);
  endtask

  initial begin
    // Reset state
    step(1, 1, $urandom, 0, 0, 0, '0);
    step(1, 0, '0, 0, 0, 0, '0);
    chk("reset_depth", 64'(depth), 64'(DEFAULT_DEPTH));

    // Single word latency at default depth
    send(32'hA5A5_0001);
    idle(6);

    // Stream with a 3-cycle stall after the third word
    peak_occ = 0;
    send(1); send(2); send(3);
    for (int i = 0; i < 3; i++) step(0, 1, 32'hDEAD, 1, 0, 0, '0);
    send(4); send(5); send(6);
    idle(7);
    chk("stream_peak_occ", 64'(peak_occ), 64'd5);

    // Depth change while idle: clamp low then high
    step(0, 0, '0, 0, 0, 1, 4'd0);
    send($urandom);
    idle(2);
    step(0, 0, '0, 0, 0, 1, 4'd12);
    send($urandom);
    idle(9);
    step(0, 0, '0, 0, 0, 1, 4'd5);

    // Rejected change with a word in flight
    send(32'h1234_5678);
    step(0, 1, 32'h2222_0002, 0, 0, 1, 4'd2);
    idle(7);

    // Flush with stall, in_valid and a depth change on the same edge
    send(11); send(12); send(13); send(14);
    step(0, 1, 32'hBAD0_0000, 1, 1, 1, 4'd2);
    idle(6);

    // Reset mid-stream at depth 3
    step(0, 0, '0, 0, 0, 1, 4'd3);
    send(21); send(22); send(23);
    step(1, 1, 32'hBAD1, 0, 0, 0, '0);
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 7) == 0), DW'($urandom_range(0, 15)));
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
